// File: rtl/video_dither_rgb_if.sv
// Pixel, sync and status bundle shared by the video source, the dither stage and the VGA pins.
interface video_dither_rgb_if #(
    parameter int INBITS  = 8,
    parameter int OUTBITS = 4
);
    logic               pix_ce;
    logic [1:0]         mode;
    logic               hsync_in;
    logic               vsync_in;
    logic               vid_ena;
    logic [INBITS-1:0]  i_red;
    logic [INBITS-1:0]  i_green;
    logic [INBITS-1:0]  i_blue;
    logic [OUTBITS-1:0] o_red;
    logic [OUTBITS-1:0] o_green;
    logic [OUTBITS-1:0] o_blue;
    logic               hsync_out;
    logic               vsync_out;
    logic               vid_ena_out;
    logic [1:0]         frame;

    modport master (
        output pix_ce, mode, hsync_in, vsync_in, vid_ena, i_red, i_green, i_blue,
        input  o_red, o_green, o_blue, hsync_out, vsync_out, vid_ena_out, frame
    );

    modport slave (
        input  pix_ce, mode, hsync_in, vsync_in, vid_ena, i_red, i_green, i_blue,
        output o_red, o_green, o_blue, hsync_out, vsync_out, vid_ena_out, frame
    );
endinterface

// File: rtl/video_dither_rgb.sv
// RGB colour-depth reducer for the VGA path: truncate, Bayer, temporal Bayer or LFSR-noise dither.
// Two-stage pipeline; syncs and video enable travel alongside the pixels.
module video_dither_rgb #(
    parameter int INBITS    = 8,
    parameter int OUTBITS   = 4,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              reset_in,
    video_dither_rgb_if.slave vid
);
    localparam int   F       = INBITS - OUTBITS;
    localparam int   SHL     = (F >= 4) ? F - 4 : 0;
    localparam int   SHR     = (F >= 4) ? 0 : 4 - F;
    localparam int   WIDE    = INBITS + 4;
    localparam logic VS_IDLE = !VSYNC_POL;

    localparam logic [3:0] BAYER [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    typedef enum logic [1:0] {
        MODE_TRUNC    = 2'd0,
        MODE_ORDERED  = 2'd1,
        MODE_TEMPORAL = 2'd2,
        MODE_LFSR     = 2'd3
    } mode_t;

    // The carry out of the add saturates the channel so bright pixels never wrap to black.
    function automatic logic [OUTBITS-1:0] dither(input logic [INBITS-1:0] pix, input logic [3:0] t);
        logic [INBITS:0] sum;
        sum = {1'b0, pix} + (INBITS+1)'((WIDE'(t) << SHL) >> SHR);
        return sum[INBITS] ? {OUTBITS{1'b1}} : OUTBITS'(sum >> F);
    endfunction

    logic [1:0]         x_q, y_q, frame_q;
    mode_t              mode_q;
    logic [15:0]        lfsr_q;
    logic               ena_prev_q, vs_prev_q;
    logic [INBITS-1:0]  red_s1, green_s1, blue_s1;
    logic [3:0]         t_red_s1, t_green_s1, t_blue_s1;
    logic               hsync_s1, vsync_s1, ena_s1;
    logic [OUTBITS-1:0] red_q, green_q, blue_q;
    logic               hsync_q, vsync_q, ena_q;

    logic               frame_start, ena_fall;
    logic [1:0]         y_cur, frame_cur;
    mode_t              mode_cur;
    logic [15:0]        lfsr_next;
    logic [3:0]         t_red, t_green, t_blue;

    // A frame start also governs the pixel sampled on that same pix_ce.
    always_comb begin
        frame_start = (vid.vsync_in == VSYNC_POL) && (vs_prev_q != VSYNC_POL);
        ena_fall    = ena_prev_q && !vid.vid_ena;
        y_cur       = frame_start ? 2'd0 : y_q;
        frame_cur   = frame_start ? frame_q + 2'd1 : frame_q;
        mode_cur    = frame_start ? mode_t'(vid.mode) : mode_q;
        lfsr_next   = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
        t_red       = 4'd0;
        t_green     = 4'd0;
        t_blue      = 4'd0;
        case (mode_cur)
            MODE_ORDERED: begin
                t_red   = BAYER[{y_cur, x_q}];
                t_green = t_red;
                t_blue  = t_red;
            end
            MODE_TEMPORAL: begin
                t_red   = BAYER[{y_cur, x_q ^ frame_cur}];
                t_green = t_red;
                t_blue  = t_red;
            end
            MODE_LFSR: begin
                t_red   = lfsr_q[3:0];
                t_green = lfsr_q[7:4];
                t_blue  = lfsr_q[11:8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            x_q        <= 2'd0;
            y_q        <= 2'd0;
            frame_q    <= 2'd0;
            mode_q     <= MODE_TRUNC;
            lfsr_q     <= 16'hACE1;
            ena_prev_q <= 1'b0;
            vs_prev_q  <= VS_IDLE;
        end else if (vid.pix_ce) begin
            x_q        <= vid.vid_ena ? x_q + 2'd1 : 2'd0;
            y_q        <= frame_start ? 2'd0 : (ena_fall ? y_q + 2'd1 : y_q);
            frame_q    <= frame_cur;
            mode_q     <= mode_cur;
            lfsr_q     <= lfsr_next;
            ena_prev_q <= vid.vid_ena;
            vs_prev_q  <= vid.vsync_in;
        end
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            red_s1     <= '0;
            green_s1   <= '0;
            blue_s1    <= '0;
            t_red_s1   <= 4'd0;
            t_green_s1 <= 4'd0;
            t_blue_s1  <= 4'd0;
            hsync_s1   <= 1'b1;
            vsync_s1   <= VS_IDLE;
            ena_s1     <= 1'b0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= VS_IDLE;
            ena_q      <= 1'b0;
        end else if (vid.pix_ce) begin
            red_s1     <= vid.i_red;
            green_s1   <= vid.i_green;
            blue_s1    <= vid.i_blue;
            t_red_s1   <= t_red;
            t_green_s1 <= t_green;
            t_blue_s1  <= t_blue;
            hsync_s1   <= vid.hsync_in;
            vsync_s1   <= vid.vsync_in;
            ena_s1     <= vid.vid_ena;
            red_q      <= ena_s1 ? dither(red_s1, t_red_s1) : '0;
            green_q    <= ena_s1 ? dither(green_s1, t_green_s1) : '0;
            blue_q     <= ena_s1 ? dither(blue_s1, t_blue_s1) : '0;
            hsync_q    <= hsync_s1;
            vsync_q    <= vsync_s1;
            ena_q      <= ena_s1;
        end
    end

    assign vid.o_red       = red_q;
    assign vid.o_green     = green_q;
    assign vid.o_blue      = blue_q;
    assign vid.hsync_out   = hsync_q;
    assign vid.vsync_out   = vsync_q;
    assign vid.vid_ena_out = ena_q;
    assign vid.frame       = frame_q;
endmodule

// File: doc/video_dither_rgb.md
Name: video_dither_rgb

Overview:
- Parametrised successor to the fixed-width VGA dither stage.
- Reduces INBITS-per-channel RGB from the video generator to OUTBITS-per-channel DAC output.
- Selectable modes: truncate, 4x4 ordered (Bayer), temporally rotated ordered, or LFSR noise.
- Sits between the video timing/pixel source and the board VGA pins; delays syncs to match its pipeline.

Parameters:
- INBITS, 8: input bits per colour channel.
- OUTBITS, 4: output bits per channel. Legal range 1..INBITS-1.
- VSYNC_POL, 0: active level of vsync_in (0 = active low).

Ports:
- clk  in  1  pixel-domain clock.
- reset_in  in  1  asynchronous, active-high reset.
- pix_ce  in  1  pixel clock enable. All state advances only when pix_ce=1.
- mode  in  2  0 truncate, 1 ordered, 2 ordered+temporal, 3 LFSR.
- hsync_in  in  1  horizontal sync, passed through.
- vsync_in  in  1  vertical sync.
- vid_ena  in  1  active-video window.
- i_red, i_green, i_blue  in  INBITS each  input pixel.
- o_red, o_green, o_blue  out  OUTBITS each  dithered pixel.
- hsync_out, vsync_out, vid_ena_out  out  1 each  syncs delayed to match the pixel pipeline.
- frame  out  2  frame counter (debug/status).

Behaviour:
- Clock and reset: one clock, clk. reset_in is asynchronous and active-high.
- Reset values:
  - All colour outputs 0; vid_ena_out 0; frame 0.
  - hsync_out and vsync_out reset to the inactive level (vsync inactive = !VSYNC_POL; hsync 1).
  - x, y, active mode register 0; LFSR 16'hACE1.
  - Reset mid-frame returns to these values immediately; first output after release is valid 2 pix_ce later.
- Pipeline: 2 stages, latency exactly 2 pix_ce cycles for pixels and all three syncs.
  - Stage 1 registers inputs and the per-channel threshold t (4 bits).
  - Stage 2 adds and saturates.
  - When pix_ce=0, every register holds its value.
- Colour outputs are forced to 0 whenever the delayed vid_ena_out=0.
- Position counters (2-bit, wrap 3->0):
  - x increments per pix_ce while vid_ena=1; cleared when vid_ena=0.
  - y increments on each vid_ena falling edge (sampled on pix_ce).
- Frame start = vsync_in transition into its active level (sampled on pix_ce). At frame start:
  - y clears; frame increments (wraps 3->0); active mode register loads from mode.
  - Mode changes mid-frame take effect only at the next frame start.
  - If frame start coincides with a vid_ena falling edge, the y clear wins.
- Bayer matrix B[y][x], rows: 0 8 2 10 / 12 4 14 6 / 3 11 1 9 / 15 7 13 5.
- Thresholds by mode:
  - 0: t = 0.
  - 1: t = B[y][x] for all channels.
  - 2: t = B[y][x XOR frame].
  - 3: red t = lfsr[3:0], green t = lfsr[7:4], blue t = lfsr[11:8], using the current value.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances on every pix_ce regardless of mode and vid_ena.
- Arithmetic, with F = INBITS-OUTBITS:
  - Scaled threshold ts = t<<(F-4) if F>=4, else t>>(4-F).
  - sum = in + ts in INBITS+1 bits.
  - out = sum[INBITS-1:F], except that when sum[INBITS]=1 the output saturates to all ones.
  - Never wraps to 0.

Test Plan:
- Reset check, defaults: assert reset_in mid-line with nonzero pixels -> all colour outputs 0, vid_ena_out 0, frame 0 immediately and asynchronously; after release, first valid pixel appears 2 pix_ce later.
- Mode 0 and latency: INBITS=8, OUTBITS=4, i_*=8'h7F, pix_ce tied 1 -> o_*=4'h7 exactly 2 cycles after vid_ena rises; syncs delayed by the same 2 cycles. With pix_ce toggling 1/0, latency is 2 enabled cycles.
- Mode 1, line y=0: i_*=8'h78 -> x=0..3 gives o_* = 7,8,7,8 (t = 0,8,2,10). Mode 2 with frame=1 -> 8,7,8,7.
- Saturation: mode 1, i_*=8'hFF at x=1 (t=8) -> o_*=4'hF, not 0.
- LFSR: mode 3 selected at the first frame start, reset just released with no earlier pix_ce, i_*=8'h78 -> first pixel o_red=7, o_green=8, o_blue=8.
- Counters and mode latching:
  - 3 lines with vid_ena pulses -> y steps 0,1,2 at the start of each line.
  - A vsync active edge clears y and steps frame 0->1.
  - Changing mode from 1 to 0 mid-line leaves the dither pattern unchanged until the next vsync edge.
